// File: rtl/sdram_frame_writer.sv
// -----------------------------------------------------------------------------
// sdram_frame_writer
//
// Write-side SDRAM request sequencer for the 133 MHz domain. Watches the
// camera write-FIFO fill level and asks sdram_top for one full-page burst
// each time a burst's worth of pixels is buffered. The row address advances
// per burst. Frame buffers ping-pong between the two bank halves on every
// camera frame start. The bank of the last fully written frame is published
// to the read side.
//
// Ports
//   clk_133M_i      in   system clock, rising edge
//   rst_133i        in   asynchronous active-high reset
//   frame_tog_i     in   toggles once per camera frame start (cmos_pclk domain)
//   fifo_used_i     in   write-FIFO fill count
//   wr_sdram_req_o  out  burst write request, held until ack
//   wr_sdram_ack_i  in   one-cycle burst-complete pulse
//   wr_sdram_add_o  out  burst start address {0, bank, row[12:0], 9'b0}
//   rd_bank_o       out  bank holding the last complete frame
//   frame_done_o    out  one-cycle pulse when the last row of a frame is acked
//   rows_wr_o       out  rows written in the current frame
//   overflow_o      out  sticky: FIFO level reached FIFO_HI
// -----------------------------------------------------------------------------
module sdram_frame_writer #(
  parameter int BURST_LEN = 512,
  parameter int ROW_MAX   = 1536,
  parameter int FIFO_AW   = 11,
  parameter int FIFO_HI   = 2040
) (
  input  logic               clk_133M_i,
  input  logic               rst_133i,
  input  logic               frame_tog_i,
  input  logic [FIFO_AW-1:0] fifo_used_i,
  output logic               wr_sdram_req_o,
  input  logic               wr_sdram_ack_i,
  output logic [23:0]        wr_sdram_add_o,
  output logic               rd_bank_o,
  output logic               frame_done_o,
  output logic [12:0]        rows_wr_o,
  output logic               overflow_o
);

  localparam logic [FIFO_AW-1:0] BURST_TH = FIFO_AW'(BURST_LEN);
  localparam logic [FIFO_AW-1:0] HI_TH    = FIFO_AW'(FIFO_HI);
  localparam logic [12:0]        ROW_LIM  = 13'(ROW_MAX);
  localparam logic [12:0]        ROW_LAST = 13'(ROW_MAX - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        tog_meta;
  logic        tog_sync;
  logic        tog_dly;
  logic        frame_evt;

  logic        fifo_rdy_p0;
  logic        frame_pend;
  logic        bank;
  logic [12:0] row;
  logic [12:0] row_inc;

  logic        start_req;
  logic        ack_take;
  logic        do_switch;
  logic        set_pend;
  logic        frame_fin;

  // --- stage: frame toggle synchroniser and edge detect ---------------------
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      tog_meta <= 1'b0;
      tog_sync <= 1'b0;
      tog_dly  <= 1'b0;
    end else begin
      tog_meta <= frame_tog_i;
      tog_sync <= tog_meta;
      tog_dly  <= tog_sync;
    end
  end

  // Any change of the synchronised toggle marks one camera frame start.
  assign frame_evt = tog_sync ^ tog_dly;

  // --- stage p0: registered FIFO threshold and sticky overflow -------------
  // The threshold compare is registered so the wide fill-count compare is
  // off the FSM path; a request therefore starts one edge after the level
  // is first seen.
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      fifo_rdy_p0 <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      fifo_rdy_p0 <= (fifo_used_i >= BURST_TH);
      if (fifo_used_i >= HI_TH) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // --- stage: sequencer state register --------------------------------------
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  assign row_inc = row + 13'd1;

  always_comb begin
    state_nxt = state;
    start_req = 1'b0;
    ack_take  = 1'b0;
    do_switch = 1'b0;
    set_pend  = 1'b0;
    frame_fin = 1'b0;
    case (state)
      S_WAIT: begin
        // A pending switch left over from a burst is applied here, before
        // any new request can be launched into the old bank.
        if (frame_evt || frame_pend) begin
          do_switch = 1'b1;
        end else if (fifo_rdy_p0 && (row < ROW_LIM)) begin
          start_req = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Bursts are never aborted: a frame start is only remembered.
        if (frame_evt) begin
          set_pend = 1'b1;
        end
        if (wr_sdram_ack_i) begin
          ack_take = 1'b1;
          if (row == ROW_LAST) begin
            frame_fin = 1'b1;
            state_nxt = S_FULL;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_FULL: begin
        if (frame_evt || frame_pend) begin
          do_switch = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

  // --- stage: request, address and frame bookkeeping registers -------------
  always_ff @(posedge clk_133M_i or posedge rst_133i) begin
    if (rst_133i) begin
      wr_sdram_req_o <= 1'b0;
      wr_sdram_add_o <= 24'd0;
      bank           <= 1'b0;
      row            <= 13'd0;
      rows_wr_o      <= 13'd0;
      rd_bank_o      <= 1'b1;
      frame_done_o   <= 1'b0;
      frame_pend     <= 1'b0;
    end else begin
      frame_done_o <= frame_fin;

      if (start_req) begin
        wr_sdram_req_o <= 1'b1;
        wr_sdram_add_o <= {1'b0, bank, row, 9'd0};
      end else if (ack_take) begin
        wr_sdram_req_o <= 1'b0;
      end

      if (do_switch) begin
        bank      <= ~bank;
        row       <= 13'd0;
        rows_wr_o <= 13'd0;
      end else if (ack_take) begin
        row       <= row_inc;
        rows_wr_o <= row_inc;
      end

      // Only a completed frame is handed to the reader.
      if (frame_fin) begin
        rd_bank_o <= bank;
      end

      if (do_switch) begin
        frame_pend <= 1'b0;
      end else if (set_pend) begin
        frame_pend <= 1'b1;
      end
    end
  end

endmodule
